// File: rtl/ffx_pkg.sv
// Shared types and the excitation rule for the flip-flop excitation generator.
// Optional self-check hardware in the top level is enabled with FFX_CHECK_EN.
package ffx_pkg;

    typedef enum logic [1:0] {
        FFX_D  = 2'b00,
        FFX_T  = 2'b01,
        FFX_JK = 2'b10,
        FFX_SR = 2'b11
    } ff_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } ffx_state_e;

    typedef struct packed {
        logic d;
        logic t;
        logic j;
        logic k;
        logic s;
        logic r;
    } ffx_exc_t;

    // Every input idle; d is overlaid with the shadow Q wherever this is driven.
    localparam ffx_exc_t FFX_HOLD = '0;

    // Inputs that move a flip-flop of type mode from p to n; don't-cares are 0.
    // d always equals n: it is the D excitation and the hold value of d alike.
    function automatic ffx_exc_t ffx_excite(ff_mode_e mode, logic p, logic n);
        ffx_exc_t e;
        e   = FFX_HOLD;
        e.d = n;
        case (mode)
            FFX_T:  e.t = p ^ n;
            FFX_JK: begin
                e.j = ~p & n;
                e.k = p & ~n;
            end
            FFX_SR: begin
                e.s = ~p & n;
                e.r = p & ~n;
            end
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ffx_fifo.sv
// One-bit-wide target FIFO with occupancy count; pointers wrap modulo DEPTH.
module ffx_fifo #(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          din,
    input  logic          pop,
    output logic          dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ff_excitation_gen.sv
// Turns a stream of target Q bits into registered D/T/JK/SR excitation steps.
// Define FFX_CHECK_EN to add the q_fb/mismatch shadow-vs-flip-flop checker.
module ff_excitation_gen
    import ffx_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic          tgt_valid,
    input  logic          tgt_bit,
    output logic          tgt_ready,
    output logic          d_o,
    output logic          t_o,
    output logic          j_o,
    output logic          k_o,
    output logic          s_o,
    output logic          r_o,
    output logic          drv_valid,
    output logic          q_model,
    output logic [LW-1:0] level,
    output logic          fsm_state
`ifdef FFX_CHECK_EN
    ,
    input  logic          q_fb,
    output logic          mismatch
`endif
);

    // Handshake: a target bit is taken on any rising edge where tgt_valid and
    // tgt_ready are both 1; tgt_ready depends on occupancy only, never on a pop.

    ffx_state_e state_q, state_d;
    ff_mode_e   mode_q, mode_d, eff_mode;
    ffx_exc_t   exc_q, hold_exc;
    logic       q_model_q, drv_valid_q;
    logic       push, pop, fifo_dout, fifo_full, fifo_empty;

    assign tgt_ready = !fifo_full && rst;
    assign push      = tgt_valid && tgt_ready;
    // A pop happens on the IDLE->DRIVE edge too, giving one-cycle latency.
    assign pop       = en && !fifo_empty;
    assign fsm_state = state_q;

    ffx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (tgt_bit),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= FFX_D;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        eff_mode = mode_q;
        case (state_q)
            ST_IDLE: begin
                eff_mode = ff_mode_e'(mode);
                if (en && !fifo_empty) begin
                    state_d = ST_DRIVE;
                    mode_d  = ff_mode_e'(mode);
                end
            end
            ST_DRIVE: begin
                if (!en || fifo_empty || (pop && !push && level == LW'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_exc   = FFX_HOLD;
        hold_exc.d = q_model_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_q       <= '0;
            q_model_q   <= 1'b0;
            drv_valid_q <= 1'b0;
        end else if (pop) begin
            exc_q       <= ffx_excite(eff_mode, q_model_q, fifo_dout);
            q_model_q   <= fifo_dout;
            drv_valid_q <= 1'b1;
        end else begin
            exc_q       <= hold_exc;
            drv_valid_q <= 1'b0;
        end
    end

    assign d_o       = exc_q.d;
    assign t_o       = exc_q.t;
    assign j_o       = exc_q.j;
    assign k_o       = exc_q.k;
    assign s_o       = exc_q.s;
    assign r_o       = exc_q.r;
    assign q_model   = q_model_q;
    assign drv_valid = drv_valid_q;

`ifdef FFX_CHECK_EN
    logic q_exp, chk_arm, mismatch_q;

    // The driven flip-flop takes a step one edge after it is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_exp      <= 1'b0;
            chk_arm    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            q_exp   <= q_model_q;
            chk_arm <= drv_valid_q;
            if (chk_arm && (q_fb != q_exp)) mismatch_q <= 1'b1;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: doc/ff_excitation_gen.md
# ff_excitation_gen

Excitation generator that drives a flip-flop toward a target waveform, the inverse of the flip-flop library's D/T/JK/SR cells. It accepts a stream of target Q bits over a valid/ready handshake and buffers them in a small FIFO. For each bit it emits the registered input pattern that moves the selected flip-flop type from its present state to that target. It sits in the bench and stimulus layer, in front of any `dff`/`tff`/`jkff`/SR cell, and keeps a shadow model of the driven flip-flop's state.

## Interface
- `DEPTH`, 4, target FIFO depth; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserted at 0.
- `en` input 1: drive enable; when 0, no FIFO pops occur.
- `mode` input 2: flip-flop type. 00 D, 01 T, 10 JK, 11 SR.
- `tgt_valid` input 1: target bit offered.
- `tgt_bit` input 1: desired next Q.
- `tgt_ready` output 1: FIFO can accept a bit.
- `d_o`, `t_o`, `j_o`, `k_o`, `s_o`, `r_o` output 1 each: registered excitation.
- `drv_valid` output 1: one-cycle strobe; excitation is a new step this cycle.
- `q_model` output 1: shadow Q after the current step.
- `level` output $clog2(DEPTH)+1: FIFO occupancy.
- `q_fb` input 1: Q of the driven flip-flop. Used only when `FFX_CHECK_EN` is defined.
- `mismatch` output 1: sticky checker flag. Present only when `FFX_CHECK_EN` is defined.

## Operation
- FSM states:
  - IDLE → DRIVE when `en`=1 and `level`>0.
  - DRIVE → IDLE when `en`=0 or the FIFO is empty after a pop.
- Mode latch: `mode` is latched only on the IDLE→DRIVE transition. Changes during DRIVE are ignored until the next IDLE.
- Each DRIVE cycle with `level`>0 does the following at the edge:
  - Pop one bit `n`.
  - Register the excitation computed from `q_model`=p and n.
  - Set `q_model`<=n.
  - Assert `drv_valid`=1.
- Excitation rules (don't-cares resolved to 0):
  - D: d=n.
  - T: t=p^n.
  - JK:
    - 0→1: J1 K0.
    - 1→0: J0 K1.
    - p=n: J0 K0.
  - SR:
    - 0→1: S1 R0.
    - 1→0: S0 R1.
    - p=n: S0 R0.
  - S=R=1 is never driven.
- Outputs of the non-selected types are held at the hold pattern. The hold pattern is also driven whenever `drv_valid`=0:
  - `d_o`=`q_model`.
  - `t_o`, `j_o`, `k_o`, `s_o`, `r_o` = 0.
- Push rule: a push occurs when `tgt_valid`&&`tgt_ready`.
- `tgt_ready` = (`level`<DEPTH) && `rst` deasserted. It depends on `level` only, not on a same-cycle pop.
- Simultaneous push and pop is legal; `level` is unchanged.
- FIFO pointers wrap modulo DEPTH.

## Timing
- Reset values (applied asynchronously when `rst`=0):
  - All excitation outputs 0.
  - `drv_valid`=0, `q_model`=0, `level`=0, `mismatch`=0.
  - FSM in IDLE, mode latch 00.
- `q_model`=0 on reset matches the library flip-flops' reset value of 0.
- Latency, for a bit pushed at edge N into an empty FIFO with `en`=1:
  - `level`=1 after edge N.
  - Excitation and `drv_valid` appear after edge N+1.
  - The driven flip-flop updates at edge N+2.
- Throughput: one step per cycle while the FIFO is non-empty.
- `en` falling: the pop at that edge is suppressed. Pops already registered stay visible for that cycle.
- Reset mid-stream: FIFO contents are discarded with no further `drv_valid`. The driven flip-flop must be reset by the same reset.

## Configuration
- With `FFX_CHECK_EN` defined:
  - `q_fb` and `mismatch` exist.
  - `q_model` is delayed one cycle into `q_exp`, and `drv_valid` is delayed one cycle into `chk_arm`.
  - When `chk_arm`=1, `q_fb`!=`q_exp` sets `mismatch`. `mismatch` stays at 1 until reset.
- Without `FFX_CHECK_EN`: the ports and checker logic are absent. There is no other behavioural difference.

## Structure
- `ffx_pkg` holds:
  - Typedef `ff_mode_e` (FFX_D, FFX_T, FFX_JK, FFX_SR).
  - Packed struct `ffx_exc_t` {d,t,j,k,s,r}.
  - Function `ffx_excite(mode, p, n)`.
  - Constant `FFX_HOLD` (the hold pattern).
- One sub-module, `ffx_fifo`: parameterised by DEPTH, 1-bit wide, with push/pop/level. The top level holds the FSM, excitation registers and checker.

## Test plan
- Reset, mode=JK, push 1,0,0,1,1 with `en`=1. Required steps:
  - J1K0, then J0K1, then J0K0, then J1K0, then J0K0.
  - `q_model` sequence 1,0,0,1,1.
  - 5 `drv_valid` strobes.
- mode=T, push 1,1,0,1. Required `t_o` 1,0,1,1. A connected `tff` Q sequence is 1,1,0,1; with `FFX_CHECK_EN`, `mismatch` stays 0.
- mode=SR, push 0 first, then 1,1,0. Required:
  - First step S0R0 (hold from reset).
  - Then S1R0, S0R0, S0R1.
  - S=R=1 never observed.
- Fill with `en`=0. `tgt_ready` drops after DEPTH pushes and `level`=DEPTH. Raise `en`: `tgt_ready` returns the cycle after the first pop.
- Drive into a `dff` with the flip-flop's D input forced to 0, push 1. `mismatch` asserts two edges after `drv_valid` and stays high until `rst`=0.
- Assert `rst` with `level`=3. All outputs return to reset values immediately. After release, no stale `drv_valid` and `level`=0.
